// File: rtl/scratch_mem_arbiter.sv
// Three-way round-robin arbiter for the shared scratch memory.
// It holds ownership per requester and checks every address against the configured memory depth.
module scratch_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 128,
    parameter int MAX_HOLD = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            req_we,
    input  logic [3*ADDR_W-1:0]   req_waddr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    input  logic [3*ADDR_W-1:0]   req_raddr0,
    input  logic [3*ADDR_W-1:0]   req_raddr1,
    input  logic [16:0]           scratch_mem_depth,
    input  logic                  clear_fault,
    output logic [2:0]            grant,
    output logic [2:0]            rd_valid,
    output logic                  scratch_mem_WE,
    output logic [ADDR_W-1:0]     scratch_mem_waddr,
    output logic [ADDR_W-1:0]     scratch_mem_raddr0,
    output logic [ADDR_W-1:0]     scratch_mem_raddr1,
    output logic [DATA_W-1:0]     scratch_mem_wdata,
    output logic                  scratch_mem_overflow_fault
);

    localparam int          CMP_W     = (ADDR_W > 17) ? ADDR_W : 17;
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_owner, w_owner_nxt;
    logic [1:0]          r_last, w_last_nxt;
    logic [15:0]         r_hold, w_hold_nxt;
    logic [2:0]          r_grant, w_grant_nxt;
    logic [2:0]          r_rd_valid;
    logic                r_fault;

    logic                w_owned;
    logic                w_we_sel;
    logic [ADDR_W-1:0]   w_waddr, w_raddr0, w_raddr1;
    logic [DATA_W-1:0]   w_wdata;
    logic [CMP_W-1:0]    w_depth_ext;
    logic                w_wr_oob, w_rd_oob;

    // The search starts one past the previous owner, so the previous owner is tried last.
    function automatic logic [1:0] rr_pick(input logic [2:0] rq, input logic [1:0] last);
        logic [1:0] c0, c1, c2;
        c0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (rq[c0])      return c0;
        else if (rq[c1]) return c1;
        else             return c2;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= 2'd0;
            r_last     <= 2'd2;
            r_hold     <= 16'd0;
            r_grant    <= 3'b000;
            r_rd_valid <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_hold     <= w_hold_nxt;
            r_grant    <= w_grant_nxt;
            r_rd_valid <= r_grant;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = rr_pick(req, r_last);
                    w_last_nxt  = w_owner_nxt;
                    w_hold_nxt  = 16'd0;
                end
            end
            default: begin
                if (!w_we_sel_req(req, r_owner) || (r_hold == HOLD_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hold != 16'hFFFF) begin
                    w_hold_nxt = r_hold + 16'd1;
                end
            end
        endcase
        w_grant_nxt = (w_state_nxt == ST_OWNED) ? 3'(3'b001 << w_owner_nxt) : 3'b000;
    end

    function automatic logic w_we_sel_req(input logic [2:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[0];
            2'd1:    return v[1];
            default: return v[2];
        endcase
    endfunction

    // The owner's request is steered to the memory port; everything is zero while idle.
    always_comb begin
        w_waddr  = '0;
        w_raddr0 = '0;
        w_raddr1 = '0;
        w_wdata  = '0;
        case (r_owner)
            2'd0: begin
                w_waddr  = req_waddr[0*ADDR_W +: ADDR_W];
                w_raddr0 = req_raddr0[0*ADDR_W +: ADDR_W];
                w_raddr1 = req_raddr1[0*ADDR_W +: ADDR_W];
                w_wdata  = req_wdata[0*DATA_W +: DATA_W];
            end
            2'd1: begin
                w_waddr  = req_waddr[1*ADDR_W +: ADDR_W];
                w_raddr0 = req_raddr0[1*ADDR_W +: ADDR_W];
                w_raddr1 = req_raddr1[1*ADDR_W +: ADDR_W];
                w_wdata  = req_wdata[1*DATA_W +: DATA_W];
            end
            default: begin
                w_waddr  = req_waddr[2*ADDR_W +: ADDR_W];
                w_raddr0 = req_raddr0[2*ADDR_W +: ADDR_W];
                w_raddr1 = req_raddr1[2*ADDR_W +: ADDR_W];
                w_wdata  = req_wdata[2*DATA_W +: DATA_W];
            end
        endcase
    end

    assign w_owned     = (r_state == ST_OWNED);
    assign w_we_sel    = w_we_sel_req(req_we, r_owner);
    assign w_depth_ext = CMP_W'(scratch_mem_depth);
    assign w_wr_oob    = w_owned && w_we_sel && (CMP_W'(w_waddr) >= w_depth_ext);
    assign w_rd_oob    = w_owned && ((CMP_W'(w_raddr0) >= w_depth_ext) ||
                                     (CMP_W'(w_raddr1) >= w_depth_ext));

    // A new violation beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                    r_fault <= 1'b0;
        else if (w_wr_oob || w_rd_oob) r_fault <= 1'b1;
        else if (clear_fault)          r_fault <= 1'b0;
    end

    assign grant                      = r_grant;
    assign rd_valid                   = r_rd_valid;
    assign scratch_mem_overflow_fault = r_fault;
    assign scratch_mem_WE             = w_owned && w_we_sel && !r_fault &&
                                        (CMP_W'(w_waddr) < w_depth_ext);
    assign scratch_mem_waddr          = w_owned ? w_waddr  : '0;
    assign scratch_mem_raddr0         = w_owned ? w_raddr0 : '0;
    assign scratch_mem_raddr1         = w_owned ? w_raddr1 : '0;
    assign scratch_mem_wdata          = w_owned ? w_wdata  : '0;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Scoreboard bench for scratch_mem_arbiter.
// A cycle-level reference model queues the expected outputs, and a negedge monitor compares them.
module tb_scratch_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MH = 256;

    logic            clock = 1'b0;
    logic            reset;
    logic [2:0]      req, req_we;
    logic [3*AW-1:0] req_waddr, req_raddr0, req_raddr1;
    logic [3*DW-1:0] req_wdata;
    logic [16:0]     scratch_mem_depth;
    logic            clear_fault;
    logic [2:0]      grant, rd_valid;
    logic            scratch_mem_WE;
    logic [AW-1:0]   scratch_mem_waddr, scratch_mem_raddr0, scratch_mem_raddr1;
    logic [DW-1:0]   scratch_mem_wdata;
    logic            scratch_mem_overflow_fault;

    scratch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .req(req), .req_we(req_we),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_raddr0(req_raddr0), .req_raddr1(req_raddr1),
        .scratch_mem_depth(scratch_mem_depth), .clear_fault(clear_fault),
        .grant(grant), .rd_valid(rd_valid), .scratch_mem_WE(scratch_mem_WE),
        .scratch_mem_waddr(scratch_mem_waddr), .scratch_mem_raddr0(scratch_mem_raddr0),
        .scratch_mem_raddr1(scratch_mem_raddr1), .scratch_mem_wdata(scratch_mem_wdata),
        .scratch_mem_overflow_fault(scratch_mem_overflow_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]    grant;
        logic [2:0]    rdv;
        logic          we;
        logic [AW-1:0] wa, ra0, ra1;
        logic [DW-1:0] wd;
        logic          fault;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: owner is -1 when nobody holds the memory.
    int         m_owner = -1;
    int         m_last  = 2;
    int         m_hold  = 0;
    bit         m_fault = 1'b0;
    logic [2:0] m_rdv   = 3'b000;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Queue this cycle's expectation, advance the model by one edge, and move to just after that edge.
    task automatic cycle();
        exp_t e;
        int   o, d, c;
        bit   wbad, rbad;
        e = '{grant: 3'b0, rdv: 3'b0, we: 1'b0, wa: '0, ra0: '0, ra1: '0, wd: '0, fault: 1'b0};
        if (!reset) begin
            m_owner = -1; m_last = 2; m_hold = 0; m_fault = 1'b0; m_rdv = 3'b000;
            q.push_back(e);
            @(posedge clock); #1;
            return;
        end
        o = m_owner;
        d = int'(scratch_mem_depth);
        wbad = 1'b0; rbad = 1'b0;
        e.rdv   = m_rdv;
        e.fault = m_fault;
        if (o >= 0) begin
            e.grant = 3'(1 << o);
            e.wa    = req_waddr[o*AW +: AW];
            e.ra0   = req_raddr0[o*AW +: AW];
            e.ra1   = req_raddr1[o*AW +: AW];
            e.wd    = req_wdata[o*DW +: DW];
            wbad    = req_we[o] && (int'(e.wa) >= d);
            rbad    = (int'(e.ra0) >= d) || (int'(e.ra1) >= d);
            e.we    = req_we[o] && !m_fault && (int'(e.wa) < d);
        end
        q.push_back(e);
        m_rdv = e.grant;
        if (wbad || rbad)     m_fault = 1'b1;
        else if (clear_fault) m_fault = 1'b0;
        if (o < 0) begin
            for (int k = 1; k <= 3; k++) begin
                c = (m_last + k) % 3;
                if (req[c]) begin
                    m_owner = c; m_last = c; m_hold = 0;
                    break;
                end
            end
        end else if (!req[o] || m_hold == MH - 1) begin
            m_owner = -1;
        end else begin
            m_hold++;
        end
        @(posedge clock); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if ({grant, rd_valid, scratch_mem_WE, scratch_mem_waddr, scratch_mem_raddr0,
                     scratch_mem_raddr1, scratch_mem_wdata, scratch_mem_overflow_fault} !==
                    {e.grant, e.rdv, e.we, e.wa, e.ra0, e.ra1, e.wd, e.fault}) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t grant %b/%b rd_valid %b/%b we %b/%b waddr %h/%h raddr0 %h/%h raddr1 %h/%h wdata %h/%h fault %b/%b (got/expected)",
                             $time, grant, e.grant, rd_valid, e.rdv, scratch_mem_WE, e.we,
                             scratch_mem_waddr, e.wa, scratch_mem_raddr0, e.ra0,
                             scratch_mem_raddr1, e.ra1, scratch_mem_wdata, e.wd,
                             scratch_mem_overflow_fault, e.fault);
                end
            end
        end
    end

    initial begin : stim
        logic [2:0] served;
        logic [2:0] gs[7];
        logic [2:0] exp36[5];
        logic [2:0] s37[300];
        int         run;
        logic [2:0] prev_req;
        int         depths[4];

        reset = 1'b0; req = '0; req_we = '0; req_waddr = '0; req_wdata = '0;
        req_raddr0 = '0; req_raddr1 = '0; scratch_mem_depth = 17'd1000; clear_fault = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_grant", int'(grant), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_we", int'(scratch_mem_WE), 0);
        chk("reset_fault", int'(scratch_mem_overflow_fault), 0);
        chk("reset_waddr", int'(scratch_mem_waddr), 0);
        reset = 1'b1;

        // Every requester asks at once, and each owner drops its request during its granted cycle.
        served = 3'b000;
        for (int i = 0; i < 7; i++) begin
            gs[i] = grant;
            served |= grant;
            req = ~served;
            cycle();
        end
        exp36 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        for (int i = 0; i < 5; i++) chk($sformatf("rr_seq[%0d]", i), int'(gs[i+1]), int'(exp36[i]));

        // Boundary writes against depth 100, a sticky fault, and clear racing a new violation.
        scratch_mem_depth = 17'd100;
        req = 3'b001; req_we = 3'b001; req_waddr[0 +: AW] = 8'd99; req_wdata[0 +: DW] = 16'hA5A5;
        cycle();
        chk("we_addr99", int'(scratch_mem_WE), 1);
        cycle();
        req_waddr[0 +: AW] = 8'd100; #1;
        chk("we_addr100", int'(scratch_mem_WE), 0);
        cycle();
        req_waddr[0 +: AW] = 8'd50; #1;
        chk("fault_set", int'(scratch_mem_overflow_fault), 1);
        chk("we_blocked", int'(scratch_mem_WE), 0);
        clear_fault = 1'b1;
        cycle();
        clear_fault = 1'b0; #1;
        chk("fault_cleared", int'(scratch_mem_overflow_fault), 0);
        chk("we_after_clear", int'(scratch_mem_WE), 1);
        req_waddr[0 +: AW] = 8'd200;
        cycle();
        chk("fault_again", int'(scratch_mem_overflow_fault), 1);
        clear_fault = 1'b1;
        cycle();
        clear_fault = 1'b0; #1;
        chk("set_beats_clear", int'(scratch_mem_overflow_fault), 1);
        req_waddr[0 +: AW] = 8'd50; clear_fault = 1'b1;
        cycle();
        clear_fault = 1'b0;
        req = 3'b000; req_we = 3'b000;
        cycle();
        cycle();

        // A requester holding continuously is forced off after MAX_HOLD cycles.
        scratch_mem_depth = 17'd1000;
        req = 3'b010;
        for (int i = 0; i < 300; i++) begin
            s37[i] = grant;
            cycle();
        end
        run = 0;
        for (int i = 1; i < 300; i++) begin
            if (s37[i] != 3'b010) break;
            run++;
        end
        chk("hold_run_len", run, MH);
        chk("hold_gap", int'(s37[MH+1]), 0);
        chk("hold_regrant", int'(s37[MH+2]), 2);
        req = 3'b000;
        cycle();
        cycle();

        // Random traffic.
        depths = '{0, 50, 256, 1000};
        prev_req = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) scratch_mem_depth = 17'(depths[$urandom_range(0, 3)]);
            if ($urandom_range(0, 3) == 0) prev_req = 3'($urandom_range(0, 7));
            req         = prev_req;
            req_we      = 3'($urandom_range(0, 7));
            req_waddr   = 24'($urandom);
            req_raddr0  = 24'($urandom);
            req_raddr1  = 24'($urandom);
            req_wdata   = {16'($urandom), 16'($urandom), 16'($urandom)};
            clear_fault = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of an owned write.
        req = 3'b000; req_we = 3'b000; clear_fault = 1'b1;
        req_waddr = '0; req_raddr0 = '0; req_raddr1 = '0;
        scratch_mem_depth = 17'd1000;
        cycle();
        cycle();
        clear_fault = 1'b0;
        req = 3'b001; req_we = 3'b001; req_waddr[0 +: AW] = 8'd10;
        cycle();
        cycle();
        chk("pre_reset_we", int'(scratch_mem_WE), 1);
        chk("pre_reset_rd_valid", int'(rd_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_grant", int'(grant), 0);
        chk("async_we", int'(scratch_mem_WE), 0);
        chk("async_rd_valid", int'(rd_valid), 0);
        chk("async_waddr", int'(scratch_mem_waddr), 0);
        req = 3'b110; req_we = 3'b000;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("post_reset_grant", int'(grant), 2);
        req = 3'b000;
        cycle();
        cycle();

        repeat (2) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scratch_mem_arbiter.md
SCRATCH_MEM_ARBITER -- requirements
Module: scratch_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, scratch memory address width.
REQ-002 SHALL have parameter DATA_W, default 128, scratch memory data width.
REQ-003 SHALL have parameter MAX_HOLD, default 256, maximum consecutive grant cycles per owner (range 2..65535).
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  3  access request; bit0 histogram, bit1 cdf, bit2 divider.
REQ-007 SHALL have port req_we  input  3  per-requester write enable.
REQ-008 SHALL have port req_waddr  input  3*ADDR_W  per-requester write address; requester i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata  input  3*DATA_W  per-requester write data, same slicing.
REQ-010 SHALL have port req_raddr0, req_raddr1  input  3*ADDR_W each  per-requester read addresses.
REQ-011 SHALL have port scratch_mem_depth  input  17  number of valid scratch words.
REQ-012 SHALL have port clear_fault  input  1  synchronous pulse clearing the overflow fault.
REQ-013 SHALL have port grant  output  3  one-hot or zero, registered.
REQ-014 SHALL have port rd_valid  output  3  registered; bit i high when scratch_mem_rdata0/1 belong to requester i.
REQ-015 SHALL have ports scratch_mem_WE (1), scratch_mem_waddr, scratch_mem_raddr0, scratch_mem_raddr1 (ADDR_W), scratch_mem_wdata (DATA_W), all outputs to scratch memory.
REQ-016 SHALL have port scratch_mem_overflow_fault  output  1  sticky fault flag.

Function
REQ-017 SHALL implement two states: IDLE (grant=0) and OWNED (grant one-hot).
REQ-018 IDLE with any req bit high at a rising edge SHALL move to OWNED with grant set to the first requesting bit found searching round-robin from (last_owner+1) mod 3.
REQ-019 last_owner SHALL update on every IDLE->OWNED transition; its reset value is 2, so histogram wins first when all request simultaneously.
REQ-020 OWNED SHALL persist while the owner's req bit stays high and the hold counter is below MAX_HOLD-1.
REQ-021 OWNED SHALL return to IDLE on the edge at which the owner's req bit is low, or at which the hold counter equals MAX_HOLD-1 (forced release).
REQ-022 Every ownership change SHALL pass through at least one IDLE cycle with grant=0.
REQ-023 The hold counter SHALL clear on entry to OWNED and increment each OWNED cycle; it saturates and never wraps.
REQ-024 Memory address and data outputs SHALL be a combinational mux of the granted requester's inputs, and SHALL be all-zero when grant=0.
REQ-025 scratch_mem_WE SHALL equal req_we[owner] AND grant nonzero AND NOT fault AND (waddr < scratch_mem_depth), with zero-extended 17-bit compare.
REQ-026 A granted write with waddr >= scratch_mem_depth SHALL be suppressed (WE=0) and SHALL set scratch_mem_overflow_fault on the next edge.
REQ-027 A granted read with raddr0 or raddr1 >= scratch_mem_depth SHALL also set the fault; the read address still drives out.
REQ-028 While the fault is set, all writes SHALL be blocked; grants and reads continue.
REQ-029 clear_fault SHALL clear the fault on the next edge; if a new violation occurs in the same cycle, set SHALL win.
REQ-030 rd_valid SHALL equal grant delayed by one cycle, matching the one-cycle memory read latency; rd_valid stays high for the cycle after a release.
REQ-031 scratch_mem_depth=0 SHALL flag any granted access as overflow.
REQ-032 req bits of non-owners SHALL be ignored until the next IDLE arbitration.

Reset
REQ-033 reset low SHALL asynchronously force state IDLE, grant=0, rd_valid=0, hold counter=0, last_owner=2, and fault=0.
REQ-034 reset low SHALL force scratch_mem_WE=0 and all address and data outputs to 0 immediately.
REQ-035 reset deassertion SHALL take effect at the first rising edge after release; arbitration starts on that edge.

Verification
REQ-036 req=3'b111 from reset -> grant sequence 001, 000, 010, 000, 100 when each owner holds req for exactly one granted cycle then drops.
REQ-037 req[1] held high for 300 cycles, MAX_HOLD=256 -> grant=010 for exactly 256 cycles, then 000 for one cycle, then 010 again if no other request is pending.
REQ-038 depth=100, histogram writes waddr=99 then waddr=100 -> first write has WE=1, second has WE=0; fault=1 next cycle; a later valid write has WE=0 until clear_fault.
REQ-039 clear_fault and a new overflow in the same cycle -> fault remains 1.
REQ-040 reset asserted mid-OWNED with WE=1 -> grant, WE, and rd_valid go 0 without a clock edge; after release, req=3'b110 -> grant=010 first.
